nes_controller_emulator: RTL and testbench
==========================================

Name: nes_controller_emulator

Overview:
- Responder end of the NES/SNES serial pad protocol: acts as the controller pad, not the console-side poller.
- Samples the console's latch and clock lines and shifts out a button word on the serial data line.
- Fed by on-board buttons (or a bench driver) so a second board can play as the pad, and so the game-side receiver can be checked against real protocol timing.
- Runs on the system (pixel) clock; latch and clock are asynchronous inputs and are oversampled.

Parameters:
- SNES_MODE, 0, 0 = 8-bit NES word; 1 = 16-bit SNES word.
- SYNC_STAGES, 2, synchroniser flops on nes_latch and nes_clk; legal range 2..4.
- TIMEOUT_CYCLES, 65535, clk cycles without a bus edge before a SHIFT is abandoned (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- buttons  in  12  active-high pressed flags.
  - NES order [7:0]: A, B, Select, Start, Up, Down, Left, Right.
  - SNES order [11:0]: B, Y, Select, Start, Up, Down, Left, Right, A, X, L, R.
- nes_latch  in  1  console latch, async, active-high.
- nes_clk  in  1  console shift clock, async, idles high.
- nes_data  out  1  serial data, active-low (0 = pressed), registered.
- word_done  out  1  one-cycle pulse when the final word bit has been shifted past.
- snapshot  out  12  button word captured at the latch falling edge, for debug/HUD.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, bit counter 0, shift register all ones (released).
  - nes_data=1, word_done=0, snapshot=0.
  - Synchroniser flops reset to latch=0 and clk=1, so no false edge is seen on release.
- Edge detection:
  - Synchronised signals are compared with their previous sample.
  - Edge seen to nes_data change = SYNC_STAGES+1 clk cycles.
  - Word length N = 8 (SNES_MODE=0) or 16.
  - In SNES mode, word bits 12..15 load as released (line high).
- States:
  - IDLE: nes_data=1. Latch rise -> LOAD.
  - LOAD (latch held high):
    - Every cycle, shift register <= ~buttons (live parallel load); nes_data = current bit 0.
    - Counter held at 0; nes_clk edges ignored.
    - Latch fall -> SHIFT, and snapshot <= buttons at that cycle.
  - SHIFT:
    - Each nes_clk rising edge: shift right (fill 0), counter+1, nes_data = new bit 0.
    - When the counter reaches N: go to DONE and pulse word_done for one cycle.
  - DONE: nes_data=0, which matches official pads reading 1 after the word. Extra clocks have no effect. Latch rise -> LOAD.
- Boundary cases:
  - Latch rise in any state, including mid-SHIFT: immediate LOAD, counter 0, no word_done.
  - Latch rise and clk rise detected in the same cycle: latch wins, clk edge discarded.
  - Latch pulse shorter than sync resolution (not detected): no state change.
  - Buttons changing during SHIFT: no effect on the word in flight.
  - Falling edges of nes_clk: never act.
  - Counter is 5 bits; it never wraps, because it saturates at N in DONE.

Optional Feature:
- Macro: NES_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit idle counter resets on any detected latch or clk edge and runs in SHIFT and DONE.
  - Reaching TIMEOUT_CYCLES -> IDLE, nes_data=1, no word_done. This recovers from an unplugged console.
- Without the macro: no counter logic; SHIFT and DONE persist until the next latch rise.

Test Plan:
1. Reset release, no bus activity for 1000 cycles -> nes_data=1, word_done never pulses, snapshot=0.
2. NES mode, buttons=8'b1000_0001 (A, Right), latch pulse then 8 clk pulses:
   - Sampled nes_data sequence 0,1,1,1,1,1,1,0.
   - word_done pulses exactly once, SYNC_STAGES+1 cycles after the 8th clk rise.
   - snapshot=12'h081.
   - nes_data=0 afterwards.
3. SNES mode, buttons=12'hA05, 16 clk pulses:
   - Bits 0..11 read as ~12'hA05 LSB-first; bits 12..15 read 1.
   - One word_done pulse.
   - 4 extra clk pulses keep nes_data=0.
4. Latch re-asserted after 3 of 8 clocks:
   - Word restarts from bit 0 and no word_done from the aborted word.
   - The following full 8-clock read returns the current buttons.
5. Latch rise and clk rise in the same sampled cycle -> counter stays 0, nes_data shows bit 0; first clk after latch fall shifts to bit 1.
6. NES_TIMEOUT_EN, TIMEOUT_CYCLES=100:
   - Latch then 2 clks, then silence for 100 cycles -> IDLE, nes_data=1, no word_done.
   - With the macro undefined, the same stimulus leaves the state in SHIFT and nes_data at bit 2.

Source files
------------

// File: rtl/nes_controller_emulator.sv
// Pad-side responder for the NES/SNES latch/clock serial protocol: oversamples the console lines
// and shifts out the button word active-low. Define NES_TIMEOUT_EN to abandon a stalled read.
module nes_controller_emulator #(
    parameter int SNES_MODE      = 0,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] buttons,
    input  logic        nes_latch,
    input  logic        nes_clk,
    output logic        nes_data,
    output logic        word_done,
    output logic [11:0] snapshot
);
    localparam logic [4:0] WORD_LEN = (SNES_MODE != 0) ? 5'd16 : 5'd8;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [SYNC_STAGES-1:0] r_latch_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic                   r_latch_prev;
    logic                   r_clk_prev;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_shift;
    logic        r_data;
    logic        r_done;
    logic [11:0] r_snap;

    state_t      w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [15:0] w_shift_nxt;
    logic        w_data_nxt;
    logic        w_done_nxt;
    logic [11:0] w_snap_nxt;

    logic        w_latch_s;
    logic        w_clk_s;
    logic        w_latch_rise;
    logic        w_latch_fall;
    logic        w_clk_rise;
    logic        w_timeout;
    logic [15:0] w_load_word;

    // Reset values match the bus idle levels so releasing reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch_sync <= '0;
            r_clk_sync   <= '1;
            r_latch_prev <= 1'b0;
            r_clk_prev   <= 1'b1;
        end else begin
            r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], nes_latch};
            r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], nes_clk};
            r_latch_prev <= w_latch_s;
            r_clk_prev   <= w_clk_s;
        end
    end

    assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
    assign w_clk_s      = r_clk_sync[SYNC_STAGES-1];
    assign w_latch_rise =  w_latch_s & ~r_latch_prev;
    assign w_latch_fall = ~w_latch_s &  r_latch_prev;
    assign w_clk_rise   =  w_clk_s   & ~r_clk_prev;

    // SNES bits 12..15 are unused buttons and always read as released.
    assign w_load_word = (SNES_MODE != 0) ? {4'hF, ~buttons} : {8'hFF, ~buttons[7:0]};

`ifdef NES_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_idle_cnt;
    logic        w_clk_fall;
    logic        w_any_edge;
    logic        w_in_word;

    assign w_clk_fall = ~w_clk_s & r_clk_prev;
    assign w_any_edge = w_latch_rise | w_latch_fall | w_clk_rise | w_clk_fall;
    assign w_in_word  = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign w_timeout  = w_in_word && !w_any_edge && (r_idle_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (w_any_edge || !w_in_word || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '1;
            r_data  <= 1'b1;
            r_done  <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            r_snap  <= w_snap_nxt;
        end
    end

    // nes_data is computed from next-state values so it is a flop yet tracks the shift register.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_snap_nxt  = r_snap;
        if (w_latch_rise) begin
            w_state_nxt = S_LOAD;
            w_cnt_nxt   = '0;
            w_shift_nxt = w_load_word;
            w_data_nxt  = w_load_word[0];
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '1;
            w_data_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_data_nxt = 1'b1;
                end
                S_LOAD: begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = w_load_word;
                    w_data_nxt  = w_load_word[0];
                    if (w_latch_fall) begin
                        w_state_nxt = S_SHIFT;
                        w_snap_nxt  = buttons;
                    end
                end
                S_SHIFT: begin
                    if (w_clk_rise) begin
                        w_shift_nxt = {1'b0, r_shift[15:1]};
                        w_cnt_nxt   = r_cnt + 5'd1;
                        w_data_nxt  = r_shift[1];
                        if (r_cnt + 5'd1 == WORD_LEN) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                            w_data_nxt  = 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    w_data_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = 1'b1;
                end
            endcase
        end
    end

    assign nes_data  = r_data;
    assign word_done = r_done;
    assign snapshot  = r_snap;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// Directed bench for nes_controller_emulator: one NES and one SNES instance share the console bus.
module tb_nes_controller_emulator;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] buttons;
    logic        nes_latch;
    logic        nes_clk;
    logic        n_data, n_done, s_data, s_done;
    logic [11:0] n_snap, s_snap;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int n_done_cnt = 0, s_done_cnt = 0, n_done_cyc = 0;

    nes_controller_emulator #(.SNES_MODE(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) u_nes (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch), .nes_clk(nes_clk),
        .nes_data(n_data), .word_done(n_done), .snapshot(n_snap));

    nes_controller_emulator #(.SNES_MODE(1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)) u_snes (
        .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch), .nes_clk(nes_clk),
        .nes_data(s_data), .word_done(s_done), .snapshot(s_snap));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_done === 1'b1) begin
            n_done_cnt <= n_done_cnt + 1;
            n_done_cyc <= cyc;
        end
        if (s_done === 1'b1) s_done_cnt <= s_done_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic latch_pulse();
        nes_latch = 1'b1;
        tick(4);
        nes_latch = 1'b0;
        tick(5);
    endtask

    task automatic clk_pulse();
        nes_clk = 1'b0;
        tick(4);
        nes_clk = 1'b1;
        rise_cyc = cyc;
        tick(5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; buttons = '0; nes_latch = 1'b0; nes_clk = 1'b1;
        tick(3);
        checks++; if (n_data !== 1'b1) begin errors++; $display("FAIL reset_data: got %b expected 1", n_data); end
        checks++; if (n_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", n_done); end
        checks++; if (s_snap !== 12'h000) begin errors++; $display("FAIL reset_snap: got %h expected 000", s_snap); end
        rst_n = 1'b1;
        tick(1000);
        checks++; if (n_data !== 1'b1) begin errors++; $display("FAIL idle_data: got %b expected 1", n_data); end
        checks++; if (s_data !== 1'b1) begin errors++; $display("FAIL idle_sdata: got %b expected 1", s_data); end
        checks++; if (n_done_cnt + s_done_cnt !== 0) begin errors++; $display("FAIL idle_done: got %0d expected 0", n_done_cnt + s_done_cnt); end
        checks++; if (n_snap !== 12'h000) begin errors++; $display("FAIL idle_snap: got %h expected 000", n_snap); end
    endtask

    task automatic test_nes_word();
        logic [7:0] w;
        int d0;
        buttons = 12'h081; w = 8'b0111_1110; d0 = n_done_cnt;
        latch_pulse();
        for (int k = 0; k < 8; k++) begin
            if (k > 0) clk_pulse();
            checks++; if (n_data !== w[k]) begin errors++; $display("FAIL nes_bit%0d: got %b expected %b", k, n_data, w[k]); end
        end
        clk_pulse();
        checks++; if (n_done_cnt !== d0 + 1) begin errors++; $display("FAIL nes_done_count: got %0d expected %0d", n_done_cnt, d0 + 1); end
        checks++; if (n_done_cyc - rise_cyc !== 3) begin errors++; $display("FAIL nes_done_latency: got %0d expected 3", n_done_cyc - rise_cyc); end
        checks++; if (n_data !== 1'b0) begin errors++; $display("FAIL nes_after_data: got %b expected 0", n_data); end
        checks++; if (n_snap !== 12'h081) begin errors++; $display("FAIL nes_snap: got %h expected 081", n_snap); end
    endtask

    task automatic test_snes_word();
        logic [15:0] w;
        int d0;
        buttons = 12'hA05; w = 16'hF5FA; d0 = s_done_cnt;
        latch_pulse();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) clk_pulse();
            checks++; if (s_data !== w[k]) begin errors++; $display("FAIL snes_bit%0d: got %b expected %b", k, s_data, w[k]); end
        end
        clk_pulse();
        checks++; if (s_done_cnt !== d0 + 1) begin errors++; $display("FAIL snes_done_count: got %0d expected %0d", s_done_cnt, d0 + 1); end
        checks++; if (s_snap !== 12'hA05) begin errors++; $display("FAIL snes_snap: got %h expected A05", s_snap); end
        for (int k = 0; k < 4; k++) begin
            clk_pulse();
            checks++; if (s_data !== 1'b0) begin errors++; $display("FAIL snes_extra%0d: got %b expected 0", k, s_data); end
        end
        checks++; if (s_done_cnt !== d0 + 1) begin errors++; $display("FAIL snes_extra_done: got %0d expected %0d", s_done_cnt, d0 + 1); end
    endtask

    task automatic test_relatch();
        logic [7:0] w;
        int d0;
        buttons = 12'h0F0; d0 = n_done_cnt;
        latch_pulse();
        repeat (3) clk_pulse();
        buttons = 12'h03C; w = 8'hC3;
        latch_pulse();
        checks++; if (n_done_cnt !== d0) begin errors++; $display("FAIL relatch_no_done: got %0d expected %0d", n_done_cnt, d0); end
        checks++; if (n_snap !== 12'h03C) begin errors++; $display("FAIL relatch_snap: got %h expected 03C", n_snap); end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) clk_pulse();
            if (k == 2) buttons = 12'hFFF;
            checks++; if (n_data !== w[k]) begin errors++; $display("FAIL relatch_bit%0d: got %b expected %b", k, n_data, w[k]); end
        end
        clk_pulse();
        checks++; if (n_done_cnt !== d0 + 1) begin errors++; $display("FAIL relatch_done: got %0d expected %0d", n_done_cnt, d0 + 1); end
    endtask

    task automatic test_latch_clk_same_cycle();
        int d0;
        buttons = 12'h002; d0 = n_done_cnt;
        nes_clk = 1'b0;
        tick(4);
        nes_latch = 1'b1; nes_clk = 1'b1;
        tick(4);
        nes_latch = 1'b0;
        tick(5);
        checks++; if (n_data !== 1'b1) begin errors++; $display("FAIL same_bit0: got %b expected 1", n_data); end
        clk_pulse();
        checks++; if (n_data !== 1'b0) begin errors++; $display("FAIL same_bit1: got %b expected 0", n_data); end
        repeat (6) clk_pulse();
        checks++; if (n_done_cnt !== d0) begin errors++; $display("FAIL same_seven_no_done: got %0d expected %0d", n_done_cnt, d0); end
        clk_pulse();
        checks++; if (n_done_cnt !== d0 + 1) begin errors++; $display("FAIL same_eighth_done: got %0d expected %0d", n_done_cnt, d0 + 1); end
    endtask

    task automatic test_latch_glitch();
        @(posedge clk);
        #2 nes_latch = 1'b1;
        #3 nes_latch = 1'b0;
        tick(6);
        checks++; if (n_data !== 1'b0) begin errors++; $display("FAIL glitch_data: got %b expected 0", n_data); end
    endtask

    task automatic test_timeout();
        int d0;
        buttons = 12'h004; d0 = n_done_cnt;
        latch_pulse();
        repeat (2) clk_pulse();
        checks++; if (n_data !== 1'b0) begin errors++; $display("FAIL stall_bit2: got %b expected 0", n_data); end
        tick(120);
`ifdef NES_TIMEOUT_EN
        checks++; if (n_data !== 1'b1) begin errors++; $display("FAIL timeout_idle: got %b expected 1", n_data); end
`else
        checks++; if (n_data !== 1'b0) begin errors++; $display("FAIL stall_hold: got %b expected 0", n_data); end
`endif
        checks++; if (n_done_cnt !== d0) begin errors++; $display("FAIL stall_no_done: got %0d expected %0d", n_done_cnt, d0); end
        clk_pulse();
        checks++; if (n_data !== 1'b1) begin errors++; $display("FAIL stall_next: got %b expected 1", n_data); end
    endtask

    initial begin
        test_reset();
        test_nes_word();
        test_snes_word();
        test_relatch();
        test_latch_clk_same_cycle();
        test_latch_glitch();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
